// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter: FSM states,
// owner codes and counter widths.
package mem_port_arbiter_pkg;

    localparam int WDOG_W   = 8;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-wait watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count would reach TIMEOUT.
module mem_port_arbiter_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    // Fires on the enabled cycle whose increment lands on TIMEOUT.
    assign tc = en && (cnt_q == WDOG_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the
// data stage; data has priority, bounded by a streak limit while a fetch waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_done_q, if_done_d;
    logic                d_done_q, d_done_d;
    logic                err_q, err_d;
    logic                wd_clr, wd_en, wd_tc;

    mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = err_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (d_req && !(if_req && streak_q == STREAK_MAX)) begin
                    state_d     = ST_BUSY_D;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wd_clr      = 1'b1;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (if_req) begin
                    state_d    = ST_BUSY_I;
                    owner_d    = OWN_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    wd_clr     = 1'b1;
                    streak_d   = '0;
                end else begin
                    streak_d = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ready) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_I) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_done_d = 1'b1;
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_tc) begin
                        state_d   = ST_DONE;
                        mem_req_d = 1'b0;
                        err_d     = 1'b1;
                        if_done_d = (owner_q == OWN_I);
                        d_done_d  = (owner_q == OWN_D);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state updates use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_done     = if_done_q;
    assign d_done      = d_done_q;
    assign err_timeout = err_q;
    assign if_stall    = if_req & ~if_done_q;
    assign d_stall     = d_req & ~d_done_q;

endmodule
